// File: rtl/vga_pkg.sv
// vga_pkg: shared cell-state encoding and board colours for the VGA overlay stages.
package vga_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        SHIP  = 2'b01,
        HIT   = 2'b10,
        MISS  = 2'b11
    } cell_state_t;

    localparam logic [11:0] SHIP_RGB = 12'h888;
    localparam logic [11:0] HIT_RGB  = 12'hF00;
    localparam logic [11:0] MISS_RGB = 12'hFFF;

    typedef struct packed {
        logic in_board;
        logic board;
        logic line;
        logic cursor_hit;
        logic hide;
    } px_flags_t;

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing counters, sync/blank flags and pixel colour.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/board_blink_ctr.sv
// board_blink_ctr: counts vsync rising edges and toggles blink_on every BLINK_FRAMES frames.
module board_blink_ctr #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic blink_on
);

    localparam int CW = $clog2(BLINK_FRAMES + 1);

    logic          vsync_prev;
    logic [CW-1:0] cnt;
    logic          last;

    assign last = cnt == CW'(BLINK_FRAMES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_prev <= 1'b0;
            cnt        <= '0;
            blink_on   <= 1'b1;
        end else begin
            vsync_prev <= vsync;
            if (vsync && !vsync_prev) begin
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) blink_on <= ~blink_on;
            end
        end
    end

endmodule

// File: rtl/delay.sv
// delay: fixed-latency register pipeline with synchronous clear.
module delay #(
    parameter int WIDTH   = 1,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_board_grid.sv
// draw_board_grid: overlays host and guest battleship boards (grid, cell states, blinking cursor)
// onto the VGA stream with a fixed 3-clock latency.
module draw_board_grid
    import vga_pkg::*;
#(
    parameter int          GRID_N       = 10,
    parameter int          CELL_LOG2    = 4,
    parameter int          X_HOST       = 64,
    parameter int          X_GUEST      = 448,
    parameter int          Y0           = 200,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] GRID_RGB     = 12'h444,
    parameter logic [11:0] CURSOR_RGB   = 12'hFF0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                hide_guest,
    input  logic                                cursor_en,
    input  logic                                cursor_board,
    input  logic [$clog2(GRID_N)-1:0]           cursor_row,
    input  logic [$clog2(GRID_N)-1:0]           cursor_col,
    output logic [$clog2(2*GRID_N*GRID_N)-1:0]  rd_addr,
    input  logic [1:0]                          rd_data,
    vga_if.in                                   vga_in,
    vga_if.out                                  vga_out
);

    localparam int CELL   = 1 << CELL_LOG2;
    localparam int SPAN   = GRID_N * CELL;
    localparam int CW     = 11 - CELL_LOG2;
    localparam int ADDR_W = $clog2(2 * GRID_N * GRID_N);

    logic                 in_host, in_guest, in_board, in_cell, on_line, cursor_hit, blink_on;
    logic [10:0]          dx, dy;
    logic [CW-1:0]        col, row;
    logic [CELL_LOG2-1:0] ox, oy;
    logic [ADDR_W-1:0]    addr;
    logic [11:0]          rgb1, rgb2, cell_rgb;
    logic [25:0]          timing_d;
    px_flags_t            f1, f2;
    cell_state_t          state;

    // Both ends of each board span are inclusive so the far grid line is drawn.
    assign in_host  = vga_in.hcount >= 11'(X_HOST)  && vga_in.hcount <= 11'(X_HOST + SPAN);
    assign in_guest = vga_in.hcount >= 11'(X_GUEST) && vga_in.hcount <= 11'(X_GUEST + SPAN);
    assign in_board = (in_host || in_guest) && vga_in.vcount >= 11'(Y0) && vga_in.vcount <= 11'(Y0 + SPAN);

    assign dx = vga_in.hcount - (in_guest ? 11'(X_GUEST) : 11'(X_HOST));
    assign dy = vga_in.vcount - 11'(Y0);
    assign {col, ox} = dx;
    assign {row, oy} = dy;

    assign in_cell = in_board && col < CW'(GRID_N) && row < CW'(GRID_N);
    assign on_line = in_board && (ox == '0 || oy == '0);
    assign addr    = (in_guest ? ADDR_W'(GRID_N * GRID_N) : '0) + ADDR_W'(row) * ADDR_W'(GRID_N) + ADDR_W'(col);

    assign cursor_hit = cursor_en && in_cell && in_guest == cursor_board &&
                        row == CW'(cursor_row) && col == CW'(cursor_col) &&
                        (ox == CELL_LOG2'(1) || ox == CELL_LOG2'(CELL - 1) ||
                         oy == CELL_LOG2'(1) || oy == CELL_LOG2'(CELL - 1));

    assign state    = cell_state_t'(rd_data);
    assign cell_rgb = (f2.cursor_hit && blink_on) ? CURSOR_RGB :
                      f2.line                     ? GRID_RGB   :
                      !f2.in_board                ? rgb2       :
                      state == SHIP               ? ((f2.board && f2.hide) ? rgb2 : SHIP_RGB) :
                      state == HIT                ? HIT_RGB    :
                      state == MISS               ? MISS_RGB   : rgb2;

    always_ff @(posedge clk) begin
        if (rst) begin
            f1          <= '0;
            f2          <= '0;
            rgb1        <= '0;
            rgb2        <= '0;
            rd_addr     <= '0;
            vga_out.rgb <= '0;
        end else begin
            f1          <= {in_board, in_guest, on_line, cursor_hit, hide_guest};
            f2          <= f1;
            rgb1        <= vga_in.rgb;
            rgb2        <= rgb1;
            rd_addr     <= in_cell ? addr : rd_addr;
            vga_out.rgb <= cell_rgb;
        end
    end

    board_blink_ctr #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk      (clk),
        .rst      (rst),
        .vsync    (vga_in.vsync),
        .blink_on (blink_on)
    );

    delay #(.WIDTH(26), .CLK_DEL(3)) u_timing (
        .clk  (clk),
        .rst  (rst),
        .din  ({vga_in.vcount, vga_in.vsync, vga_in.vblnk, vga_in.hcount, vga_in.hsync, vga_in.hblnk}),
        .dout (timing_d)
    );

    assign {vga_out.vcount, vga_out.vsync, vga_out.vblnk, vga_out.hcount, vga_out.hsync, vga_out.hblnk} = timing_d;

endmodule

// File: tb/tb_draw_board_grid.sv
// tb_draw_board_grid: table vectors, blink/reset sequences and a randomized sweep checked
// against a geometric reference model of the two boards.
module tb_draw_board_grid;
    import vga_pkg::*;

    localparam int GRID_N = 10, CELL = 16, X_HOST = 64, X_GUEST = 448, Y0 = 200, BLINK = 30;
    localparam int SPAN = GRID_N * CELL;

    logic       clk = 0, rst = 1, hide_guest = 0, cursor_en = 0, cursor_board = 0;
    logic [3:0] cursor_row = 0, cursor_col = 0;
    logic [7:0] rd_addr;
    logic [1:0] rd_data = 0;
    logic [1:0] mem [2*GRID_N*GRID_N];

    vga_if vin();
    vga_if vout();

    draw_board_grid dut (
        .clk          (clk),
        .rst          (rst),
        .hide_guest   (hide_guest),
        .cursor_en    (cursor_en),
        .cursor_board (cursor_board),
        .cursor_row   (cursor_row),
        .cursor_col   (cursor_col),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .vga_in       (vin),
        .vga_out      (vout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rd_data <= mem[rd_addr];

    typedef struct {
        logic [10:0] h, v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } pixel_t;

    typedef struct {
        pixel_t      p;
        logic [11:0] exp;
    } slot_t;

    typedef struct {
        int          h, v;
        logic [11:0] rgb;
        logic [1:0]  ram;
        logic        hide, en, cb;
        int          cr, cc, addr;
        logic [11:0] exp;
    } vec_t;

    slot_t  q[$];
    vec_t   tbl[13];
    int     compared = 0, mismatched = 0;
    int     model_addr = 0, edges = 0;
    logic   prev_vs = 0;
    pixel_t p;

    task automatic check(string name, int act, int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic pixel_t mk(int h, int v, logic [11:0] rgb);
        pixel_t r;
        r.h = 11'(h); r.v = 11'(v); r.rgb = rgb;
        r.hs = 0; r.vs = 0; r.hb = 0; r.vb = 0;
        return r;
    endfunction

    function automatic int board_of(pixel_t x);
        if (x.v < Y0 || x.v > Y0 + SPAN) return -1;
        if (x.h >= X_HOST && x.h <= X_HOST + SPAN) return 0;
        if (x.h >= X_GUEST && x.h <= X_GUEST + SPAN) return 1;
        return -1;
    endfunction

    function automatic int addr_of(pixel_t x);
        int b = board_of(x);
        int col, row;
        if (b < 0) return -1;
        col = (int'(x.h) - (b == 1 ? X_GUEST : X_HOST)) / CELL;
        row = (int'(x.v) - Y0) / CELL;
        if (col >= GRID_N || row >= GRID_N) return -1;
        return b * GRID_N * GRID_N + row * GRID_N + col;
    endfunction

    function automatic logic [11:0] model_rgb(pixel_t x);
        int b = board_of(x);
        int dx, dy, col, row;
        logic cur;
        if (b < 0) return x.rgb;
        dx  = int'(x.h) - (b == 1 ? X_GUEST : X_HOST);
        dy  = int'(x.v) - Y0;
        col = dx / CELL;
        row = dy / CELL;
        cur = cursor_en && b == int'(cursor_board) && row == int'(cursor_row) && col == int'(cursor_col) &&
              row < GRID_N && col < GRID_N &&
              (dx % CELL == 1 || dx % CELL == CELL - 1 || dy % CELL == 1 || dy % CELL == CELL - 1);
        if (cur && (edges / BLINK) % 2 == 0) return 12'hFF0;
        if (dx % CELL == 0 || dy % CELL == 0) return 12'h444;
        case (mem[b * GRID_N * GRID_N + row * GRID_N + col])
            SHIP:    return (b == 1 && hide_guest) ? x.rgb : 12'h888;
            HIT:     return 12'hF00;
            MISS:    return 12'hFFF;
            default: return x.rgb;
        endcase
    endfunction

    task automatic drive(pixel_t x);
        vin.hcount = x.h; vin.vcount = x.v; vin.rgb = x.rgb;
        vin.hsync = x.hs; vin.vsync = x.vs; vin.hblnk = x.hb; vin.vblnk = x.vb;
    endtask

    // Drive one pixel, advance a clock and compare whatever has emerged from the 3-stage pipe.
    task automatic step(pixel_t x, logic [11:0] exp);
        slot_t s;
        int a;
        drive(x);
        s.p = x; s.exp = exp;
        q.push_back(s);
        a = addr_of(x);
        if (a >= 0) model_addr = a;
        if (x.vs && !prev_vs) edges++;
        prev_vs = x.vs;
        @(posedge clk); #1;
        check("rd_addr", int'(rd_addr), model_addr);
        if (q.size() == 3) begin
            s = q.pop_front();
            check("rgb", int'(vout.rgb), int'(s.exp));
            check("timing", int'({vout.vcount, vout.vsync, vout.vblnk, vout.hcount, vout.hsync, vout.hblnk}),
                  int'({s.p.v, s.p.vs, s.p.vb, s.p.h, s.p.hs, s.p.hb}));
        end
    endtask

    task automatic idle(logic vs);
        pixel_t x = mk(0, 0, 12'h0);
        x.vs = vs; x.hb = 1;
        step(x, model_rgb(x));
    endtask

    task automatic pulses(int n, int high);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < high; k++) idle(1);
            idle(0);
        end
    endtask

    task automatic model_reset();
        q.delete();
        model_addr = 0;
        edges      = 0;
        prev_vs    = 0;
    endtask

    initial begin
        tbl[0]  = '{120, 240, 12'h00A, HIT,   0, 0, 0, 0,  0, 23,  12'hF00};
        tbl[1]  = '{504, 240, 12'h00A, SHIP,  1, 0, 0, 0,  0, 123, 12'h00A};
        tbl[2]  = '{504, 240, 12'h00A, SHIP,  0, 0, 0, 0,  0, 123, 12'h888};
        tbl[3]  = '{64,  250, 12'h00A, HIT,   0, 0, 0, 0,  0, 30,  12'h444};
        tbl[4]  = '{224, 250, 12'h00A, HIT,   0, 0, 0, 0,  0, 30,  12'h444};
        tbl[5]  = '{225, 250, 12'h0B0, HIT,   0, 0, 0, 0,  0, 30,  12'h0B0};
        tbl[6]  = '{120, 240, 12'h00A, MISS,  0, 0, 0, 0,  0, 23,  12'hFFF};
        tbl[7]  = '{120, 240, 12'h123, EMPTY, 0, 0, 0, 0,  0, 23,  12'h123};
        tbl[8]  = '{113, 240, 12'h00A, HIT,   0, 1, 0, 2,  3, 23,  12'hFF0};
        tbl[9]  = '{113, 240, 12'h00A, HIT,   0, 1, 0, 12, 3, 23,  12'hF00};
        tbl[10] = '{113, 240, 12'h00A, HIT,   0, 1, 1, 2,  3, 23,  12'hF00};
        tbl[11] = '{497, 240, 12'h00A, SHIP,  0, 1, 1, 2,  3, 123, 12'hFF0};
        tbl[12] = '{497, 240, 12'h00A, SHIP,  0, 0, 1, 2,  3, 123, 12'h888};

        for (int i = 0; i < 2 * GRID_N * GRID_N; i++) mem[i] = EMPTY;
        drive(mk(0, 0, 12'h0));
        repeat (2) @(posedge clk);
        #1;
        check("reset_rgb", int'(vout.rgb), 0);
        check("reset_addr", int'(rd_addr), 0);
        check("reset_blink", int'(dut.u_blink.blink_on), 1);
        rst = 0;
        model_reset();

        for (int i = 0; i < 13; i++) begin
            hide_guest   = tbl[i].hide;
            cursor_en    = tbl[i].en;
            cursor_board = tbl[i].cb;
            cursor_row   = 4'(tbl[i].cr);
            cursor_col   = 4'(tbl[i].cc);
            mem[tbl[i].addr] = tbl[i].ram;
            step(mk(tbl[i].h, tbl[i].v, tbl[i].rgb), tbl[i].exp);
            check("tbl_addr", int'(rd_addr), tbl[i].addr);
            repeat (3) idle(0);
        end

        // Cursor blink: on, off after 30 frames, on again after 60 (vsync held high counts once).
        hide_guest = 0; cursor_en = 1; cursor_board = 0; cursor_row = 2; cursor_col = 3;
        mem[23] = HIT;
        p = mk(113, 240, 12'h00A);
        step(p, 12'hFF0);
        repeat (3) idle(0);
        pulses(BLINK, 1);
        step(p, 12'hF00);
        repeat (3) idle(0);
        pulses(BLINK, 3);
        step(p, 12'hFF0);
        repeat (3) idle(0);
        pulses(BLINK, 1);
        check("pre_rst_blink", int'(dut.u_blink.blink_on), 0);

        // Reset in the middle of a line on a board.
        for (int h = 100; h < 110; h++) begin
            p = mk(h, 245, 12'h5A5);
            step(p, model_rgb(p));
        end
        rst = 1;
        drive(mk(130, 260, 12'h5A5));
        @(posedge clk); #1;
        check("rst_rgb", int'(vout.rgb), 0);
        check("rst_timing", int'({vout.vcount, vout.hcount, vout.vsync, vout.hsync}), 0);
        check("rst_addr", int'(rd_addr), 0);
        check("rst_blink", int'(dut.u_blink.blink_on), 1);
        rst = 0;
        model_reset();

        for (int i = 0; i < 2 * GRID_N * GRID_N; i++) mem[i] = 2'($urandom);

        // Raster band across the top rows of both boards with a fixed cursor.
        cursor_en = 1; cursor_board = 0; cursor_row = 0; cursor_col = 1; hide_guest = 1;
        for (int v = Y0 - 1; v <= Y0 + 17; v++) begin
            for (int h = X_HOST - 1; h <= X_HOST + SPAN + 1; h++) begin
                p = mk(h, v, 12'($urandom));
                p.hs = h[0];
                step(p, model_rgb(p));
            end
            for (int h = X_GUEST - 1; h <= X_GUEST + 20; h++) begin
                p = mk(h, v, 12'($urandom));
                step(p, model_rgb(p));
            end
        end

        // Random pixels with controls changing every clock.
        for (int i = 0; i < 12000; i++) begin
            hide_guest   = 1'($urandom);
            cursor_en    = ($urandom_range(0, 3) != 0);
            cursor_board = 1'($urandom);
            cursor_row   = 4'($urandom_range(0, 11));
            cursor_col   = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 3) != 0)
                p = mk($urandom_range(X_HOST - 4, X_GUEST + SPAN + 4), $urandom_range(Y0 - 4, Y0 + SPAN + 4), 12'($urandom));
            else
                p = mk($urandom_range(0, 1055), $urandom_range(0, 627), 12'($urandom));
            p.hs = 1'($urandom); p.hb = 1'($urandom); p.vb = 1'($urandom);
            step(p, model_rgb(p));
        end
        repeat (3) idle(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
